// File: rtl/shift_add_mul.sv
// Sequential unsigned WxW multiplier: one ripple-carry Adder reused each cycle
// in a shift-and-add loop, with valid/ready handshakes on operands and product.

module Adder (
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i] = in_a[i] ^ in_b[i] ^ c;
      c      = (in_a[i] & in_b[i]) | (c & (in_a[i] ^ in_b[i]));
    end
    cout = c;
  end
endmodule

module shift_add_mul #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q;
  logic [2*W-1:0] p_q;
  logic [5:0]     cnt;
  logic [W-1:0]   sum;
  logic           cout;

  // The Adder is hard-wired to 32 bits; any other width cannot be built.
  if (W != 32) begin : g_bad_width
    $error("shift_add_mul: only W=32 is supported");
  end

  Adder u_adder (
    .in_a (p_q[2*W-1:W]),
    .in_b (a_q),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_valid)            state_nxt = RUN;
      RUN:  if (cnt == 6'(W - 1))       state_nxt = DONE;
      DONE: if (res_ready)              state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      p_q <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          a_q <= op_a;
          p_q <= {{W{1'b0}}, op_b};
          cnt <= '0;
        end
        // Carry lands in the top bit after the shift, so the product never overflows.
        RUN: begin
          p_q <= p_q[0] ? {cout, sum, p_q[W-1:1]} : {1'b0, p_q[2*W-1:1]};
          cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign product     = p_q;
endmodule

// File: doc/shift_add_mul.md
# shift_add_mul

Sequential unsigned 32×32 multiplier controller. It reuses one instance of the team's 32-bit ripple-carry `Adder` as its only arithmetic resource and runs it once per cycle in a shift-and-add loop to produce a 64-bit product. It sits beside the ALU as the multi-cycle multiply unit. Operands enter and the product leaves through valid/ready handshakes.

## Interface
Parameters:
- `W`, default 32: operand width. Only 32 is supported because the instantiated `Adder` is fixed at 32 bits. Any other value is a configuration error.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  operand pair is valid.
- `start_ready`  out  1  block can accept operands (high only in IDLE).
- `op_a`  in  W  multiplicand, unsigned.
- `op_b`  in  W  multiplier, unsigned.
- `res_valid`  out  1  `product` is valid (high only in DONE).
- `res_ready`  in  1  consumer accepts `product`.
- `product`  out  2W  unsigned product `op_a*op_b`.
- `busy`  out  1  high in RUN or DONE.

## Operation
Registers:
- `A[W-1:0]`: latched multiplicand.
- `P[2W-1:0]`: product/shift register, driven directly onto `product`.
- `cnt[5:0]`: iteration counter.
- `state`: one of IDLE, RUN, DONE.

Adder use:
- One `Adder` instance with inputs `adder_inA = P[2W-1:W]`, `adder_inB = A`, `cin = 0`.
- Its `cout` and sum feed the RUN update.
- No other adder or `+` operator exists on the datapath.

States:
- **IDLE**:
  - `start_ready = 1`.
  - On `start_valid & start_ready`: `A <= op_a`, `P <= {W'b0, op_b}`, `cnt <= 0`, go to RUN.
  - Otherwise hold.
- **RUN**:
  - If `P[0] = 1`: `P <= {cout, sum, P[W-1:1]}`, a logical right shift of `{cout, sum, P[W-1:0]}`.
  - If `P[0] = 0`: `P <= {1'b0, P[2W-1:1]}`.
  - `cnt <= cnt + 1`.
  - When `cnt == W-1` (the iteration being performed is the last), go to DONE.
- **DONE**:
  - `res_valid = 1`; `product` and `P` are held stable.
  - On `res_ready`: go to IDLE.

Width rules:
- The carry out of the `Adder` becomes bit 2W-1 after the shift, so no overflow is possible.
- The full 64-bit product is always exact.

Boundary conditions:
- `start_valid` while RUN/DONE: ignored, since `start_ready = 0`. Operands are sampled only at the accepting edge and may change freely afterwards.
- `res_ready` outside DONE: ignored.
- `res_ready` held high: DONE lasts exactly one cycle.
- In the DONE cycle where `res_ready` is accepted, `start_valid` is not accepted. The earliest new accept is the following edge.
- `op_a = 0` or `op_b = 0`: still runs the full W iterations; the product is 0.
- Reset asserted at any time, including mid-RUN: immediately go to IDLE. The in-flight operation is aborted and no result is produced.

Reset values:
- state = IDLE, `A = 0`, `P = 0`, `cnt = 0`.
- Outputs: `start_ready = 1`, `res_valid = 0`, `busy = 0`, `product = 0`.
- `product` keeps the last result after the DONE→IDLE transition until the next accept overwrites `P`.

## Timing
- Accept at edge E. Iterations occur at edges E+1 … E+W.
- `res_valid` rises after edge E+W, so the latency from accept to valid is W cycles (32).
- The result is consumed at the first edge F ≥ E+W+1 with `res_ready` high. `start_ready` rises after F.
- With `res_ready` tied high, throughput is one product per W+2 cycles (34).
- All outputs are registered-state decodes; there are no combinational paths from inputs to outputs.
- The critical path is the 32-bit ripple through the `Adder` into `P`.

## Test plan
- `op_a=3`, `op_b=5`, `res_ready=1` → `res_valid` high exactly 32 cycles after the accept, `product=0x000000000000000F`, then `start_ready=1` on the next cycle.
- `op_a=0xFFFFFFFF`, `op_b=0xFFFFFFFF` → `product=0xFFFFFFFE00000001`. This exercises `cout` propagation into the top bit.
- `op_a=0x12345678`, `op_b=0` → `product=0` after 32 cycles; `busy` is high for 33 cycles.
- Back-pressure: `res_ready=0` for 10 cycles after `res_valid` → `product` is stable and `res_valid` stays high. `start_valid` with new operands pulsed during RUN and DONE is ignored. After `res_ready` rises, the next accept uses fresh operands.
- Reset mid-operation: assert `rst_n=0` at iteration 16 of `7×9`. Outputs go to their reset values asynchronously: `res_valid=0`, `product=0`, `start_ready=1`. A following `6×7` gives `product=42`.
- Back-to-back: with `res_ready=1`, run 100 random operand pairs with `start_valid` always high → every product matches the 64-bit reference model, and consecutive accepts are spaced 34 cycles apart.
